// File: rtl/prog_count_n.sv
// Programmable up/down counter with one-shot or auto-reload operation, hold and abort.
// Terminal value is clamped to LIMIT and latched, together with direction and mode, on start.
module prog_count_n #(
  parameter int WIDTH = 7,
  parameter int LIMIT = 99
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] max_count,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_tc, w_tc_nxt;
  logic [WIDTH-1:0] r_lim, w_lim_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_reload, w_reload_nxt;

  logic [WIDTH-1:0] w_clamped;
  logic [WIDTH-1:0] w_new_start;
  logic [WIDTH-1:0] w_start_val;
  logic [WIDTH-1:0] w_term;

  assign w_clamped   = (max_count > LIMIT_V) ? LIMIT_V : max_count;
  assign w_new_start = dir ? w_clamped : '0;
  assign w_start_val = r_dir ? r_lim : '0;
  assign w_term      = r_dir ? '0 : r_lim;

  // Priority: abort > start > hold > step; reset is handled asynchronously below.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_tc_nxt     = 1'b0;
    w_lim_nxt    = r_lim;
    w_dir_nxt    = r_dir;
    w_reload_nxt = r_reload;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
    end else if (start) begin
      w_state_nxt  = S_COUNT;
      w_lim_nxt    = w_clamped;
      w_dir_nxt    = dir;
      w_reload_nxt = auto_reload;
      w_count_nxt  = w_new_start;
      // Start equals terminal only when the clamped limit is zero.
      w_tc_nxt     = (w_clamped == '0);
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_COUNT: begin
          if (hold) begin
            w_state_nxt = S_HOLD;
          end else if (r_count != w_term) begin
            w_count_nxt = r_dir ? (r_count - ONE_V) : (r_count + ONE_V);
            w_tc_nxt    = ((r_dir ? (r_count - ONE_V) : (r_count + ONE_V)) == w_term);
          end else if (r_reload) begin
            w_count_nxt = w_start_val;
            w_tc_nxt    = (w_start_val == w_term);
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        S_HOLD: begin
          if (!hold) w_state_nxt = S_COUNT;
        end
        S_DONE: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_tc     <= 1'b0;
      r_lim    <= '0;
      r_dir    <= 1'b0;
      r_reload <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_tc     <= w_tc_nxt;
      r_lim    <= w_lim_nxt;
      r_dir    <= w_dir_nxt;
      r_reload <= w_reload_nxt;
    end
  end

  assign count_out = r_count;
  assign tc        = r_tc;
  assign busy      = (r_state == S_COUNT) || (r_state == S_HOLD);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule
